// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader: controller
// states, the default memory size and the width of the memory address bus.
package imem_ctrl_pkg;

    // Controller states. RUN releases the core, ERROR latches an overflow.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Default instruction memory size in bytes.
    localparam int MEM_BYTES_DEFAULT = 1024;

    // Width of the shared instruction-memory address bus.
    localparam int IMEM_ADDR_W = 32;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory. On start it zero-fills the whole
// memory, then streams a little-endian program byte stream into it and
// finally releases the core from reset. While the core runs, the memory
// address bus is handed over to the core fetch address.
//
// Byte stream handshake: a byte transfers on a rising edge where
// in_valid && in_ready are both high. in_ready is a pure decode of the
// registered state (high only in LOAD) and never depends on in_valid;
// in_data and in_last are only looked at on a transfer edge.
module imem_boot_loader
    import imem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic [31:0] core_pc,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic [31:0] imem_addr,
    output logic        core_resetn,
    output logic        busy,
    output logic        err,
    output logic [31:0] load_count
);

    // One spare bit so the counter can represent MEM_BYTES itself.
    localparam int              CNT_W     = $clog2(MEM_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_cnt_q;
    logic [CNT_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             wr_we_q;
    logic             err_q;
    logic             core_resetn_q;

    logic             start_ok;
    logic             accept;
    logic             at_top;
    logic             clearing;
    logic [CNT_W-1:0] write_addr;

    // Handshake and condition decodes shared by the FSM and the datapath.
    always_comb begin
        start_ok = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
        in_ready = (state == ST_LOAD);
        accept   = in_valid && in_ready;
        at_top   = (cnt == LAST_ADDR);
        clearing = (state == ST_CLEAR);
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only honoured outside CLEAR/LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start_ok) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (at_top) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        state_nxt = ST_RUN;
                    end else if (at_top) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters, registered write port and core reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt           <= '0;
            load_cnt_q    <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_we_q       <= 1'b0;
            err_q         <= 1'b0;
            core_resetn_q <= 1'b0;
        end else begin
            // A load strobe lives for exactly one cycle after its accept.
            wr_we_q <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (start_ok) begin
                        cnt           <= '0;
                        load_cnt_q    <= '0;
                        err_q         <= 1'b0;
                        core_resetn_q <= 1'b0;
                    end else if (state == ST_RUN) begin
                        // First RUN cycle still shows the final write, so
                        // the core comes out of reset one cycle later.
                        core_resetn_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (at_top) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_we_q    <= 1'b1;
                        wr_data_q  <= in_data;
                        wr_addr_q  <= cnt;
                        cnt        <= cnt + CNT_ONE;
                        load_cnt_q <= load_cnt_q + CNT_ONE;
                        if (at_top && !in_last) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Memory port: CLEAR writes zeros straight from cnt, LOAD writes come
    // from the registered byte; a running core owns the address bus.
    always_comb begin
        write_addr  = clearing ? cnt : wr_addr_q;
        mem_we      = !core_resetn_q && (clearing || wr_we_q);
        mem_wdata   = (mem_we && !clearing) ? wr_data_q : 8'h00;
        imem_addr   = core_resetn_q ? core_pc : IMEM_ADDR_W'(write_addr);
        core_resetn = core_resetn_q;
        busy        = clearing || (state == ST_LOAD);
        err         = err_q;
        load_count  = IMEM_ADDR_W'(load_cnt_q);
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a 1024-byte instance for the clear,
// program load and toggled-valid scenarios and a 16-byte instance for the
// overflow, exact-fit and mid-load reset scenarios.
module tb_imem_boot_loader;

    localparam int A_BYTES = 1024;
    localparam int B_BYTES = 16;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [7:0]  in_data;
    logic        in_last;
    logic [31:0] core_pc;

    logic        start_a, in_valid_a, in_ready_a, mem_we_a, core_resetn_a, busy_a, err_a;
    logic [7:0]  mem_wdata_a;
    logic [31:0] imem_addr_a, load_count_a;

    logic        start_b, in_valid_b, in_ready_b, mem_we_b, core_resetn_b, busy_b, err_b;
    logic [7:0]  mem_wdata_b;
    logic [31:0] imem_addr_b, load_count_b;

    imem_boot_loader #(.MEM_BYTES(A_BYTES)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .core_pc(core_pc), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a), .imem_addr(imem_addr_a),
        .core_resetn(core_resetn_a), .busy(busy_a), .err(err_a), .load_count(load_count_a)
    );

    imem_boot_loader #(.MEM_BYTES(B_BYTES)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .core_pc(core_pc), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .imem_addr(imem_addr_b),
        .core_resetn(core_resetn_b), .busy(busy_b), .err(err_b), .load_count(load_count_b)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [39:0] exp_q[$];
    logic [39:0] obs_a[$];
    logic [39:0] obs_b[$];
    logic [7:0]  mem_a [0:A_BYTES-1];

    // Write monitor: records every strobe and mirrors instance A's memory.
    always @(negedge clk) begin
        if (mem_we_a === 1'b1) begin
            obs_a.push_back({imem_addr_a, mem_wdata_a});
            mem_a[imem_addr_a[9:0]] = mem_wdata_a;
        end
        if (mem_we_b === 1'b1) begin
            obs_b.push_back({imem_addr_b, mem_wdata_b});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic compare_writes(input bit sel, input string tag);
        int          bad;
        int          n_obs;
        logic [39:0] got;
        bad   = 0;
        n_obs = sel ? obs_b.size() : obs_a.size();
        check({tag, "_count"}, 64'(n_obs), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            got = sel ? obs_b[i] : obs_a[i];
            if (got !== exp_q[i]) bad++;
        end
        check({tag, "_bad_entries"}, 64'(bad), 64'd0);
        exp_q.delete();
        if (sel) obs_b.delete(); else obs_a.delete();
    endtask

    // ---------------- driver tasks (entered just after a rising edge) ----------------
    function automatic logic ready_of(input bit sel);
        return sel ? in_ready_b : in_ready_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic set_valid(input bit sel, input logic v);
        if (sel) in_valid_b = v; else in_valid_a = v;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        if (sel) start_b = 1'b0; else start_a = 1'b0;
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({32'(i), 8'h00});
    endtask

    task automatic wait_ready(input bit sel, input int limit, output int cyc, output int busy_lo);
        bit done;
        done    = 1'b0;
        cyc     = 0;
        busy_lo = 0;
        while (!done) begin
            @(negedge clk);
            if (ready_of(sel) === 1'b1) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (busy_of(sel) !== 1'b1) busy_lo++;
                if (cyc >= limit) done = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d, input logic last,
                             input int limit, output bit ok);
        int waited;
        ok      = 1'b0;
        waited  = 0;
        in_data = d;
        in_last = last;
        set_valid(sel, 1'b1);
        while (!ok && waited < limit) begin
            @(negedge clk);
            if (ready_of(sel) === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            waited++;
        end
        set_valid(sel, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0]  prog [0:55];
    logic [31:0] word;
    logic [9:0]  a;
    int          cyc, blo, acc;
    bit          ok;

    initial begin
        resetn = 1'b0; start_a = 1'b0; start_b = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_data = 8'h00; in_last = 1'b0; core_pc = 32'h0;

        prog[0] = 8'h83; prog[1] = 8'h20; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h33; prog[5] = 8'h81; prog[6] = 8'h10; prog[7] = 8'h00;
        for (int i = 8; i < 56; i++) prog[i] = 8'(i * 37 + 5);

        // Reset values.
        #12;
        check("rst_mem_we",      64'(mem_we_a),      64'd0);
        check("rst_mem_wdata",   64'(mem_wdata_a),   64'd0);
        check("rst_in_ready",    64'(in_ready_a),    64'd0);
        check("rst_core_resetn", 64'(core_resetn_a), 64'd0);
        check("rst_busy",        64'(busy_a),        64'd0);
        check("rst_err",         64'(err_a),         64'd0);
        check("rst_load_count",  64'(load_count_a),  64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_core_resetn", 64'(core_resetn_a), 64'd0);
        check("idle_busy",        64'(busy_a),        64'd0);
        check("idle_in_ready",    64'(in_ready_a),    64'd0);
        @(posedge clk); #1;

        // Scenario: full 1024-byte clear.
        pulse_start(1'b0);
        push_zeros(A_BYTES);
        wait_ready(1'b0, A_BYTES + 50, cyc, blo);
        check("clear_cycles",   64'(cyc), 64'd1024);
        check("clear_busy_low", 64'(blo), 64'd0);
        compare_writes(1'b0, "clear_a");
        check("load_in_ready", 64'(in_ready_a), 64'd1);
        check("load_busy",     64'(busy_a),     64'd1);

        // Scenario: 56-byte program load, then core fetch.
        acc = 0;
        for (int i = 0; i < 56; i++) begin
            send_byte(1'b0, prog[i], (i == 55), 10, ok);
            if (ok) acc++;
            exp_q.push_back({32'(i), prog[i]});
        end
        check("prog_accepted", 64'(acc), 64'd56);
        @(negedge clk);
        check("prog_last_we",       64'(mem_we_a),      64'd1);
        check("prog_last_addr",     64'(imem_addr_a),   64'd55);
        check("prog_core_held_n1",  64'(core_resetn_a), 64'd0);
        @(negedge clk);
        check("prog_core_rel_n2",   64'(core_resetn_a), 64'd1);
        check("prog_we_after_rel",  64'(mem_we_a),      64'd0);
        #1;
        compare_writes(1'b0, "prog");
        check("prog_load_count", 64'(load_count_a), 64'd56);
        check("prog_busy",       64'(busy_a),       64'd0);
        core_pc = 32'h4;
        #1;
        check("fetch_addr", 64'(imem_addr_a), 64'h4);
        a    = imem_addr_a[9:0];
        word = {mem_a[a + 10'd3], mem_a[a + 10'd2], mem_a[a + 10'd1], mem_a[a]};
        check("fetch_word", 64'(word), 64'h00108133);
        core_pc = 32'h10;
        #1;
        check("fetch_addr2", 64'(imem_addr_a), 64'h10);

        // Scenario: restart from RUN, then load with in_valid toggling.
        @(posedge clk); #1;
        pulse_start(1'b0);
        check("rerun_core_resetn", 64'(core_resetn_a), 64'd0);
        check("rerun_busy",        64'(busy_a),        64'd1);
        check("rerun_addr",        64'(imem_addr_a),   64'd0);
        push_zeros(A_BYTES);
        wait_ready(1'b0, A_BYTES + 50, cyc, blo);
        check("clear2_cycles", 64'(cyc), 64'd1024);
        compare_writes(1'b0, "clear_a2");
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            send_byte(1'b0, 8'(8'hA0 + i), (i == 19), 10, ok);
            if (ok) acc++;
            exp_q.push_back({32'(i), 8'(8'hA0 + i)});
            if (i != 19) begin
                in_data = 8'hEE;
                in_last = 1'b1;
                @(posedge clk); #1;
            end
        end
        check("toggle_accepted", 64'(acc), 64'd20);
        @(negedge clk);
        @(negedge clk);
        #1;
        compare_writes(1'b0, "toggle");
        check("toggle_load_count", 64'(load_count_a), 64'd20);
        @(posedge clk); #1;

        // Scenario: 16-byte memory, 17 bytes offered without in_last.
        pulse_start(1'b1);
        push_zeros(B_BYTES);
        wait_ready(1'b1, 40, cyc, blo);
        check("clear_b_cycles", 64'(cyc), 64'd16);
        compare_writes(1'b1, "clear_b");
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            send_byte(1'b1, 8'(8'h10 + i), 1'b0, 10, ok);
            if (ok) acc++;
            exp_q.push_back({32'(i), 8'(8'h10 + i)});
        end
        check("ovf_accepted", 64'(acc), 64'd16);
        send_byte(1'b1, 8'hFF, 1'b0, 5, ok);
        check("ovf_17th_taken",    64'(ok),            64'd0);
        check("ovf_err",           64'(err_b),         64'd1);
        check("ovf_in_ready",      64'(in_ready_b),    64'd0);
        check("ovf_core_resetn",   64'(core_resetn_b), 64'd0);
        check("ovf_load_count",    64'(load_count_b),  64'd16);
        check("ovf_busy",          64'(busy_b),        64'd0);
        check("ovf_addr",          64'(imem_addr_b),   64'd15);
        compare_writes(1'b1, "ovf");

        // Scenario: restart from ERROR, exact fit with start ignored mid-load.
        pulse_start(1'b1);
        check("fit_err_cleared",  64'(err_b),        64'd0);
        check("fit_count_zeroed", 64'(load_count_b), 64'd0);
        check("fit_busy",         64'(busy_b),       64'd1);
        push_zeros(B_BYTES);
        wait_ready(1'b1, 40, cyc, blo);
        compare_writes(1'b1, "clear_b2");
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            start_b = (i == 5);
            send_byte(1'b1, 8'(8'h60 + i * 3), (i == 15), 10, ok);
            start_b = 1'b0;
            if (ok) acc++;
            exp_q.push_back({32'(i), 8'(8'h60 + i * 3)});
        end
        check("fit_accepted", 64'(acc), 64'd16);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("fit_err",         64'(err_b),         64'd0);
        check("fit_core_resetn", 64'(core_resetn_b), 64'd1);
        check("fit_load_count",  64'(load_count_b),  64'd16);
        compare_writes(1'b1, "fit");
        @(posedge clk); #1;

        // Scenario: reset pulsed mid-load at cnt=10.
        pulse_start(1'b1);
        push_zeros(B_BYTES);
        wait_ready(1'b1, 40, cyc, blo);
        compare_writes(1'b1, "clear_b3");
        for (int i = 0; i < 10; i++) begin
            send_byte(1'b1, 8'(8'hC0 + i), 1'b0, 10, ok);
            exp_q.push_back({32'(i), 8'(8'hC0 + i)});
        end
        @(posedge clk); #1;
        compare_writes(1'b1, "pre_rst");
        check("pre_rst_count", 64'(load_count_b), 64'd10);
        in_data    = 8'h77;
        in_last    = 1'b0;
        in_valid_b = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_mem_we",      64'(mem_we_b),      64'd0);
        check("mid_rst_mem_wdata",   64'(mem_wdata_b),   64'd0);
        check("mid_rst_in_ready",    64'(in_ready_b),    64'd0);
        check("mid_rst_busy",        64'(busy_b),        64'd0);
        check("mid_rst_core_resetn", 64'(core_resetn_b), 64'd0);
        check("mid_rst_err",         64'(err_b),         64'd0);
        check("mid_rst_load_count",  64'(load_count_b),  64'd0);
        check("mid_rst_addr",        64'(imem_addr_b),   64'd0);
        in_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_no_writes", 64'(obs_b.size()), 64'd0);
        pulse_start(1'b1);
        check("restart_busy",       64'(busy_b),       64'd1);
        check("restart_load_count", 64'(load_count_b), 64'd0);
        check("restart_we",         64'(mem_we_b),     64'd1);
        check("restart_addr",       64'(imem_addr_b),  64'd0);
        push_zeros(B_BYTES);
        wait_ready(1'b1, 40, cyc, blo);
        check("restart_cycles", 64'(cyc), 64'd16);
        compare_writes(1'b1, "restart_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Run-length bound.
    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the instruction memory size in bytes; the counter width is $clog2(MEM_BYTES)+1.
REQ-002 SHALL have these ports, clock and reset first:
  clk         in   1   single clock; all state updates on rising edge
  resetn      in   1   asynchronous reset, active-low
  start       in   1   request a clear-and-load sequence
  in_valid    in   1   byte stream valid
  in_ready    out  1   byte stream ready
  in_data     in   8   program byte, little-endian order
  in_last     in   1   marks the final byte of the program
  core_pc     in   32  fetch address from the core
  mem_we      out  1   byte write strobe to instruction memory
  mem_wdata   out  8   write byte
  imem_addr   out  32  shared memory address (write address or fetch address)
  core_resetn out  1   active-low reset to the core
  busy        out  1   high in CLEAR or LOAD
  err         out  1   program overflowed MEM_BYTES
  load_count  out  32  bytes accepted by the last load

Function
REQ-003 SHALL implement states IDLE, CLEAR, LOAD, RUN and ERROR; this block is the sole writer of instruction memory.
REQ-004 IDLE, RUN or ERROR with start=1 -> CLEAR next cycle; cnt<=0; load_count<=0; err<=0; core_resetn<=0 the following cycle.
REQ-005 start SHALL be ignored in CLEAR and LOAD.
REQ-006 CLEAR: one write per cycle, mem_we=1, mem_wdata=0x00, address=cnt, cnt increments; after address MEM_BYTES-1 -> LOAD with cnt<=0; duration is exactly MEM_BYTES cycles.
REQ-007 LOAD: in_ready=1 (registered state decode, no combinational path from in_valid); a byte is accepted when in_valid&&in_ready.
REQ-008 An accepted byte at cycle N SHALL produce mem_we=1, mem_wdata=in_data, imem_addr=cnt at cycle N+1 (registered, 1-cycle latency); cnt and load_count increment.
REQ-009 Accepted byte with in_last=1 -> RUN; core_resetn=1 from cycle N+2, strictly after the final write strobe.
REQ-010 Accepted byte at cnt=MEM_BYTES-1 with in_last=0: the byte is written, then -> ERROR; err=1 and in_ready=0 hold until the next start.
REQ-011 Accepted byte at cnt=MEM_BYTES-1 with in_last=1 -> RUN; this is not an error.
REQ-012 in_valid deasserted in LOAD: stall with no write and cnt held; there is no timeout.
REQ-013 imem_addr = core_pc when core_resetn=1, else the registered write address; mem_we=0 whenever core_resetn=1.
REQ-014 in_ready=0 in every state except LOAD; bytes presented outside LOAD are not consumed.
REQ-015 load_count SHALL hold its final value in RUN and ERROR.
REQ-016 busy = (state==CLEAR || state==LOAD).

Reset
REQ-017 resetn=0 SHALL asynchronously force state=IDLE, cnt=0, load_count=0, err=0, mem_we=0, mem_wdata=0, in_ready=0, core_resetn=0, busy=0.
REQ-018 Reset during CLEAR or LOAD SHALL abort the sequence with no further writes; memory contents are undefined until the next completed load.
REQ-019 After reset release, the block SHALL stay in IDLE with the core held in reset until start is asserted.

Structure
REQ-020 Package imem_ctrl_pkg SHALL hold the state enum, the MEM_BYTES default and the IMEM_ADDR_W=32 constant.
REQ-021 A single flat module; no sub-module is required.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, then start pulse with MEM_BYTES=1024 -> exactly 1024 consecutive zero writes at addresses 0..1023, busy=1 throughout, then in_ready=1.
  - Load the 56-byte program starting 0x83,0x20,0x00,0x00, last byte flagged -> 56 writes at addresses 0..55; load_count=56; core_resetn rises 2 cycles after the last accept; imem_addr follows core_pc=0x4 -> instruction word 0x00108133.
  - in_valid toggled 1/0 every cycle during LOAD -> no missing or duplicated bytes; addresses strictly sequential.
  - MEM_BYTES=16, 17 bytes offered, none with in_last -> 16 writes, err=1, in_ready=0, core_resetn=0; 17th byte not consumed.
  - MEM_BYTES=16, 16 bytes with in_last on the 16th -> RUN, err=0.
  - resetn pulsed low mid-LOAD at cnt=10 -> all outputs at reset values immediately; new start restarts from CLEAR with load_count=0.
